// File: rtl/seg7_scan_driver.sv
// Multiplexed NUM_DIGITS hex 7-segment driver with dead time, blanking, leading-zero
// suppression and a tear-free shadow buffer. Optional PWM dimming under SEG7_BRIGHTNESS_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int SEG_ACT_LOW  = 1,
    parameter int EN_ACT_LOW   = 1,
    parameter int LZ_SUPPRESS  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              bright,
`endif
    input  logic                    wr_en,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    input  logic [NUM_DIGITS-1:0]   wr_dp,
    input  logic [NUM_DIGITS-1:0]   wr_blank,
    output logic                    wr_ready,
    output logic [6:0]              ds_reg,
    output logic                    ds_dp,
    output logic [NUM_DIGITS-1:0]   ds_en
);

    localparam int SC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SC_W-1:0]       SLOT_LAST = SC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      DIG_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF    = (SEG_ACT_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] EN_OFF    = (EN_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    logic [SC_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]      dig_idx;
    logic [4*NUM_DIGITS-1:0] act_data, sh_data;
    logic [NUM_DIGITS-1:0] act_dp, act_blank, sh_dp, sh_blank;
    logic                  sh_vld;
    logic                  slot_wrap, frame_end;

    assign slot_wrap = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_wrap && (dig_idx == DIG_LAST);
    assign wr_ready  = !sh_vld;

    // Scan counters and double buffer; the shadow only moves to active at a frame boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt  <= '0;
            dig_idx   <= '0;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '0;
            sh_data   <= '0;
            sh_dp     <= '0;
            sh_blank  <= '0;
            sh_vld    <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                dig_idx <= (dig_idx == DIG_LAST) ? '0 : dig_idx + 1'b1;
            if (frame_end && sh_vld) begin
                act_data  <= sh_data;
                act_dp    <= sh_dp;
                act_blank <= sh_blank;
                sh_vld    <= 1'b0;
            end else if (wr_en && !sh_vld) begin
                sh_data  <= wr_data;
                sh_dp    <= wr_dp;
                sh_blank <= wr_blank;
                sh_vld   <= 1'b1;
            end
        end
    end

    // A digit is a leading zero when it and every higher digit are plain zeros
    logic [NUM_DIGITS-1:0] lz_mask;
    logic                  lz_run;
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run && (act_data[4*i +: 4] == 4'h0) && !act_dp[i] && !act_blank[i];
            lz_mask[i] = lz_run;
        end
    end

    logic scan_on, en_on;
    generate
        if (BLANK_CYCLES == 0) begin : g_no_dead
            assign scan_on = 1'b1;
        end else begin : g_dead
            assign scan_on = (slot_cnt >= SC_W'(BLANK_CYCLES));
        end
    endgenerate

`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk) begin
        if (reset)
            pwm_cnt <= 4'h0;
        else
            pwm_cnt <= pwm_cnt + 4'h1;
    end
    assign en_on = scan_on && ((bright == 4'hF) || (pwm_cnt < bright));
`else
    assign en_on = scan_on;
`endif

    // Stage p0: decode current scan position into active-high pin values
    logic [3:0]            cur_nib;
    logic                  cur_dark;
    logic [6:0]            seg_p0;
    logic                  dp_p0;
    logic [NUM_DIGITS-1:0] en_p0;
    always_comb begin
        cur_nib  = act_data[dig_idx*4 +: 4];
        cur_dark = act_blank[dig_idx] || ((LZ_SUPPRESS != 0) && lz_mask[dig_idx]);
        seg_p0   = cur_dark ? 7'h00 : hex_glyph(cur_nib);
        dp_p0    = act_dp[dig_idx] && !cur_dark;
        en_p0    = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            en_p0[i] = en_on && (dig_idx == IDX_W'(i));
    end

    // Stage p1: registered pins with polarity applied
    always_ff @(posedge clk) begin
        if (reset) begin
            ds_reg <= SEG_OFF;
            ds_dp  <= DP_OFF;
            ds_en  <= EN_OFF;
        end else begin
            ds_reg <= seg_p0 ^ SEG_OFF;
            ds_dp  <= dp_p0 ^ DP_OFF;
            ds_en  <= en_p0 ^ EN_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios then random writes/resets, compared
// every cycle against a frame-level display model (plain and leading-zero instances).
module tb_seg7_scan_driver;

    localparam int ND    = 4;
    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SD;

    // Active-low glyphs 0..F as seen on the pins
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp, wr_blank;
    logic        wr_ready, ds_dp, lz_ready, lz_dp;
    logic [6:0]  ds_reg, lz_reg;
    logic [3:0]  ds_en, lz_en;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  bright = 4'hF;
`endif

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                       .SEG_ACT_LOW(1), .EN_ACT_LOW(1), .LZ_SUPPRESS(0)) dut (
        .clk(clk), .reset(reset),
`ifdef SEG7_BRIGHTNESS_EN
        .bright(bright),
`endif
        .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
        .wr_ready(wr_ready), .ds_reg(ds_reg), .ds_dp(ds_dp), .ds_en(ds_en));

    seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
                       .SEG_ACT_LOW(1), .EN_ACT_LOW(1), .LZ_SUPPRESS(1)) dut_lz (
        .clk(clk), .reset(reset),
`ifdef SEG7_BRIGHTNESS_EN
        .bright(bright),
`endif
        .wr_en(wr_en), .wr_data(wr_data), .wr_dp(wr_dp), .wr_blank(wr_blank),
        .wr_ready(lz_ready), .ds_reg(lz_reg), .ds_dp(lz_dp), .ds_en(lz_en));

    int errors = 0;
    int checks = 0;

    // Model: k = clock edges since reset; edge k shows scan position k-1 of the shown frame
    int          k = 0;
    logic        pend = 1'b0;
    logic [15:0] act_d = '0, sh_d = '0;
    logic [3:0]  act_p = '0, act_b = '0, sh_p = '0, sh_b = '0;
    logic [3:0]  e_en;
    logic [6:0]  e_reg, e_reg_lz;
    logic        e_dp, e_dp_lz, e_rdy;

    function automatic logic leading_zero(input int d, input logic [15:0] data,
                                          input logic [3:0] dp, input logic [3:0] bl);
        logic z = 1'b1;
        for (int j = d; j < ND; j++)
            if (data[4*j +: 4] != 4'h0 || dp[j] || bl[j]) z = 1'b0;
        return z;
    endfunction

    task automatic model_edge();
        int   q, slot, dig;
        logic dark, dark_lz;
        if (reset) begin
            k = 0; pend = 1'b0;
            act_d = '0; act_p = '0; act_b = '0; sh_d = '0; sh_p = '0; sh_b = '0;
            e_en = 4'hF; e_reg = 7'h7F; e_dp = 1'b1; e_reg_lz = 7'h7F; e_dp_lz = 1'b1;
        end else begin
            q    = k;
            slot = q % SD;
            dig  = (q / SD) % ND;
            e_en = (slot >= BC) ? ~(4'b0001 << dig) : 4'hF;
            dark    = act_b[dig];
            dark_lz = dark || (dig > 0 && leading_zero(dig, act_d, act_p, act_b));
            e_reg    = dark ? 7'h7F : GLYPH[act_d[4*dig +: 4]];
            e_dp     = dark ? 1'b1 : !act_p[dig];
            e_reg_lz = dark_lz ? 7'h7F : GLYPH[act_d[4*dig +: 4]];
            e_dp_lz  = dark_lz ? 1'b1 : !act_p[dig];
            if ((q % FRAME) == FRAME - 1 && pend) begin
                act_d = sh_d; act_p = sh_p; act_b = sh_b; pend = 1'b0;
            end else if (wr_en && !pend) begin
                sh_d = wr_data; sh_p = wr_dp; sh_b = wr_blank; pend = 1'b1;
            end
            k++;
        end
        e_rdy = !pend;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [15:0] d,
                        input logic [3:0] dp, input logic [3:0] bl);
        reset = r; wr_en = we; wr_data = d; wr_dp = dp; wr_blank = bl;
        @(posedge clk);
        model_edge();
        #1;
        chk("ds_en",    {12'h0, ds_en},    {12'h0, e_en});
        chk("ds_reg",   {9'h0, ds_reg},    {9'h0, e_reg});
        chk("ds_dp",    {15'h0, ds_dp},    {15'h0, e_dp});
        chk("wr_ready", {15'h0, wr_ready}, {15'h0, e_rdy});
        chk("lz_en",    {12'h0, lz_en},    {12'h0, e_en});
        chk("lz_reg",   {9'h0, lz_reg},    {9'h0, e_reg_lz});
        chk("lz_dp",    {15'h0, lz_dp},    {15'h0, e_dp_lz});
        chk("lz_ready", {15'h0, lz_ready}, {15'h0, e_rdy});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 16'h0, 4'h0, 4'h0);
    endtask

    task automatic idle_until(input int pos);
        for (int i = 0; i < FRAME && (k % FRAME) != pos; i++) idle();
    endtask

    initial begin
        logic        r, we;
        logic [15:0] d;
        logic [3:0]  dp, bl;

        // reset held: pins stay dark, ready high
        repeat (11) step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);

        // basic write, shown from the next frame
        step(1'b0, 1'b1, 16'h1234, 4'b0001, 4'h0);
        repeat (2 * FRAME) idle();

        // mid-frame write, second write while busy must be dropped
        idle_until(10);
        step(1'b0, 1'b1, 16'hABCD, 4'h0, 4'h0);
        step(1'b0, 1'b1, 16'h0000, 4'hF, 4'hF);
        repeat (2 * FRAME) idle();

        // write in the frame-boundary cycle, with one blanked digit
        idle_until(FRAME - 1);
        step(1'b0, 1'b1, 16'h00F0, 4'h0, 4'b0100);
        repeat (2 * FRAME + 3) idle();

        // leading zeros
        idle_until(1);
        step(1'b0, 1'b1, 16'h0050, 4'h0, 4'h0);
        repeat (2 * FRAME) idle();

        // reset at slot 5 of digit 2 with shadow pending
        idle_until(1);
        step(1'b0, 1'b1, 16'h8888, 4'hF, 4'h0);
        idle_until(2 * SD + 5);
        step(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
        repeat (2 * FRAME) idle();

        // random traffic
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(0, 399) == 0);
            we = ($urandom_range(0, 3) == 0);
            d  = 16'($urandom);
            d  = d >> (4 * $urandom_range(0, 4));
            dp = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            bl = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
            step(r, we, d, dp, bl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
